// File: rtl/rx_samp_seq.sv
// Collects one decimated I/Q sample per enabled RX channel into staging, then publishes the
// complete set to holding registers that the audio memory reads 16 bits at a time.
module rx_samp_seq #(
  parameter int NRX = 3,
  parameter int DW  = 24
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic [NRX-1:0]    rx_en,
  input  logic [NRX-1:0]    rx_stb,
  input  logic [NRX*DW-1:0] rx_i,
  input  logic [NRX*DW-1:0] rx_q,
  input  logic              wb_stb,
  input  logic [15:0]       wb_din,
  input  logic              rd_getI,
  input  logic              rd_getQ,
  input  logic              rd_getWB,
  input  logic              ser,
  input  logic [2:0]        rxn,
  output logic              rx_avail_A,
  output logic              rx_avail_wb_A,
  output logic [15:0]       rx_dout_A,
  output logic [47:0]       ticks_A,
  output logic [NRX-1:0]    overrun,
  input  logic              clr_ovr
);

  typedef enum logic {COLLECT, PUBLISH} state_t;

  state_t                state;
  logic [47:0]           tick;
  logic [NRX-1:0]        got;
  logic [NRX-1:0]        cap;
  logic [NRX-1:0]        got_next;
  logic [NRX-1:0]        new_ovr;
  logic                  set_done;
  logic signed [DW-1:0]  stg_i  [NRX];
  logic signed [DW-1:0]  stg_q  [NRX];
  logic signed [DW-1:0]  hold_i [NRX];
  logic signed [DW-1:0]  hold_q [NRX];
  logic [15:0]           wb_hold;
  logic signed [DW-1:0]  sel_i;
  logic signed [DW-1:0]  sel_q;
  logic [15:0]           rd_word;

  // Completion looks ahead at this cycle's strobes so the set publishes the cycle after the last one.
  always_comb begin
    cap      = rx_stb & rx_en;
    got_next = got | cap;
    new_ovr  = (state == COLLECT) ? (cap & got) : '0;
    set_done = (state == COLLECT) && ((got_next & rx_en) == rx_en) && (rx_en != '0);
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= COLLECT;
      got        <= '0;
      rx_avail_A <= 1'b0;
      ticks_A    <= '0;
      for (int n = 0; n < NRX; n++) begin
        hold_i[n] <= '0;
        hold_q[n] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          got        <= got_next;
          rx_avail_A <= set_done;
          if (set_done) state <= PUBLISH;
        end
        PUBLISH: begin
          // staging here is pre-edge, so a strobe landing now belongs to the next set
          for (int n = 0; n < NRX; n++) begin
            hold_i[n] <= stg_i[n];
            hold_q[n] <= stg_q[n];
          end
          ticks_A    <= tick;
          got        <= cap;
          rx_avail_A <= 1'b0;
          state      <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick    <= '0;
      overrun <= '0;
      for (int n = 0; n < NRX; n++) begin
        stg_i[n] <= '0;
        stg_q[n] <= '0;
      end
    end else begin
      tick    <= tick + 48'd1;
      overrun <= (clr_ovr ? '0 : overrun) | new_ovr;
      for (int n = 0; n < NRX; n++) begin
        if (cap[n]) begin
          stg_i[n] <= rx_i[n*DW +: DW];
          stg_q[n] <= rx_q[n*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_hold       <= '0;
      rx_avail_wb_A <= 1'b0;
    end else begin
      rx_avail_wb_A <= wb_stb;
      if (wb_stb) wb_hold <= wb_din;
    end
  end

  // Out-of-range channel numbers select nothing and read back as zero.
  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int n = 0; n < NRX; n++) begin
      if (rxn == 3'(n)) begin
        sel_i = hold_i[n];
        sel_q = hold_q[n];
      end
    end
    if (rd_getWB)
      rd_word = wb_hold;
    else if (rd_getI)
      rd_word = ser ? {sel_i[7:0], sel_q[7:0]} : sel_i[DW-1:DW-16];
    else
      rd_word = sel_q[DW-1:DW-16];
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n)
      rx_dout_A <= '0;
    else if (rd_getWB || rd_getI || rd_getQ)
      rx_dout_A <= rd_word;
  end

endmodule

// File: tb/tb_rx_samp_seq.sv
// Directed bench for rx_samp_seq: set publish timing, readback table, overrun, wideband, mask and reset.
module tb_rx_samp_seq;

  localparam int NRX = 3;
  localparam int DW  = 24;

  logic              adc_clk;
  logic              reset_n;
  logic [NRX-1:0]    rx_en;
  logic [NRX-1:0]    rx_stb;
  logic [NRX*DW-1:0] rx_i;
  logic [NRX*DW-1:0] rx_q;
  logic              wb_stb;
  logic [15:0]       wb_din;
  logic              rd_getI;
  logic              rd_getQ;
  logic              rd_getWB;
  logic              ser;
  logic [2:0]        rxn;
  logic              rx_avail_A;
  logic              rx_avail_wb_A;
  logic [15:0]       rx_dout_A;
  logic [47:0]       ticks_A;
  logic [NRX-1:0]    overrun;
  logic              clr_ovr;

  rx_samp_seq #(.NRX(NRX), .DW(DW)) dut (
    .adc_clk(adc_clk), .reset_n(reset_n), .rx_en(rx_en), .rx_stb(rx_stb),
    .rx_i(rx_i), .rx_q(rx_q), .wb_stb(wb_stb), .wb_din(wb_din),
    .rd_getI(rd_getI), .rd_getQ(rd_getQ), .rd_getWB(rd_getWB), .ser(ser), .rxn(rxn),
    .rx_avail_A(rx_avail_A), .rx_avail_wb_A(rx_avail_wb_A), .rx_dout_A(rx_dout_A),
    .ticks_A(ticks_A), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  typedef struct {
    logic        rd_i;
    logic        rd_q;
    logic        rd_wb;
    logic        ser;
    logic [2:0]  rxn;
    logic [15:0] exp;
    string       name;
  } rd_vec_t;

  rd_vec_t tbl [13];
  int total = 0;
  int bad   = 0;
  int cyc;
  int avail_cnt, avail_cyc, wb_cnt, wb_cyc;
  int a0, w0;

  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  always @(posedge adc_clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  always @(negedge adc_clk) begin
    if (reset_n && rx_avail_A)    begin avail_cnt <= avail_cnt + 1; avail_cyc <= cyc; end
    if (reset_n && rx_avail_wb_A) begin wb_cnt    <= wb_cnt + 1;    wb_cyc    <= cyc; end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic strobe(input logic [NRX-1:0] m);
    rx_stb = m;
    step();
    rx_stb = '0;
  endtask

  task automatic rd(input logic ri, input logic rq, input logic rw, input logic s, input logic [2:0] ch);
    rd_getI = ri; rd_getQ = rq; rd_getWB = rw; ser = s; rxn = ch;
    step();
    rd_getI = 1'b0; rd_getQ = 1'b0; rd_getWB = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 3'd1, 16'hABCD, "i_ms_ch1"};
    tbl[1]  = '{1, 0, 0, 1, 3'd1, 16'hEF56, "i_ls_ch1"};
    tbl[2]  = '{0, 1, 0, 0, 3'd1, 16'h1234, "q_ch1"};
    tbl[3]  = '{0, 1, 0, 1, 3'd1, 16'h1234, "q_ch1_ser_ignored"};
    tbl[4]  = '{1, 0, 0, 0, 3'd0, 16'hC0FF, "i_ms_ch0"};
    tbl[5]  = '{1, 0, 0, 1, 3'd0, 16'hEEF0, "i_ls_ch0"};
    tbl[6]  = '{0, 1, 0, 0, 3'd2, 16'h89AB, "q_ch2"};
    tbl[7]  = '{1, 0, 0, 1, 3'd2, 16'h32CD, "i_ls_ch2"};
    tbl[8]  = '{0, 0, 0, 0, 3'd0, 16'h32CD, "hold_no_strobe"};
    tbl[9]  = '{1, 0, 0, 0, 3'd5, 16'h0000, "i_rxn5"};
    tbl[10] = '{1, 1, 0, 0, 3'd2, 16'h7654, "prio_i_over_q"};
    tbl[11] = '{1, 0, 1, 0, 3'd1, 16'h5A5A, "prio_wb_over_i"};
    tbl[12] = '{0, 1, 0, 0, 3'd3, 16'h0000, "q_rxn3"};

    avail_cnt = 0; wb_cnt = 0; avail_cyc = -1; wb_cyc = -1;
    reset_n = 1'b0; rx_en = '0; rx_stb = '0; wb_stb = 1'b0; wb_din = '0;
    rd_getI = 1'b0; rd_getQ = 1'b0; rd_getWB = 1'b0; ser = 1'b0; rxn = '0; clr_ovr = 1'b0;
    rx_i = {24'h765432, 24'hABCDEF, 24'hC0FFEE};
    rx_q = {24'h89ABCD, 24'h123456, 24'h0BEEF0};
    repeat (3) @(posedge adc_clk);
    #1;
    chk("rst_avail", rx_avail_A, 0);
    chk("rst_avail_wb", rx_avail_wb_A, 0);
    chk("rst_dout", rx_dout_A, 0);
    chk("rst_ticks", ticks_A, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge adc_clk);
    reset_n = 1'b1;

    // Basic set: strobes at cycles 10, 12, 15
    rx_en = 3'b111;
    wait_cyc(10); rx_stb = 3'b001;
    wait_cyc(11); rx_stb = 3'b000;
    wait_cyc(12); rx_stb = 3'b100;
    wait_cyc(13); rx_stb = 3'b000;
    wait_cyc(15); rx_stb = 3'b010;
    wait_cyc(16); rx_stb = 3'b000;
    wait_cyc(20);
    chk("set_avail_count", avail_cnt, 1);
    chk("set_avail_cycle", avail_cyc, 16);
    chk("set_ticks", ticks_A, 48'd16);

    // Wideband coincident with set completion
    a0 = avail_cnt; w0 = wb_cnt;
    wb_din = 16'h5A5A; wb_stb = 1'b1; rx_stb = 3'b111;
    step();
    wb_stb = 1'b0; rx_stb = '0;
    step(); step();
    chk("wb_set_avail", avail_cnt, a0 + 1);
    chk("wb_avail", wb_cnt, w0 + 1);
    chk("wb_same_cycle", wb_cyc, avail_cyc);
    rd(0, 0, 1, 0, 3'd0);
    chk("wb_read", rx_dout_A, 16'h5A5A);

    foreach (tbl[k]) begin
      rd(tbl[k].rd_i, tbl[k].rd_q, tbl[k].rd_wb, tbl[k].ser, tbl[k].rxn);
      chk(tbl[k].name, rx_dout_A, tbl[k].exp);
    end

    // Overrun: ch0 twice, disabled ch2 strobes ignored, then ch1 completes
    rx_en = 3'b011;
    a0 = avail_cnt;
    rx_i[23:0] = 24'h000111;
    strobe(3'b001);
    rx_i[23:0] = 24'h000100;
    strobe(3'b101);
    strobe(3'b100);
    chk("ovr_set", overrun, 3'b001);
    rx_stb = 3'b010;
    step();
    rx_stb = '0;
    rd(1, 0, 0, 0, 3'd0);
    chk("read_during_publish", rx_dout_A, 16'hC0FF);
    chk("ovr_publish", avail_cnt, a0 + 1);
    rd(1, 0, 0, 0, 3'd0);
    chk("ovr_ch0_i_ms", rx_dout_A, 16'h0001);
    rd(1, 0, 0, 1, 3'd0);
    chk("ovr_ch0_i_ls", rx_dout_A, 16'h00F0);
    chk("ovr_sticky", overrun, 3'b001);
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    chk("ovr_clear", overrun, 3'b000);
    strobe(3'b001);
    clr_ovr = 1'b1;
    strobe(3'b001);
    clr_ovr = 1'b0;
    chk("ovr_beats_clear", overrun, 3'b001);
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    chk("ovr_clear2", overrun, 3'b000);
    strobe(3'b010);
    step();

    // Empty mask never publishes
    rx_en = 3'b000;
    a0 = avail_cnt;
    strobe(3'b111);
    step(); step();
    chk("mask0_no_avail", avail_cnt, a0);
    chk("mask0_no_ovr", overrun, 3'b000);

    // Single-channel mask
    rx_en = 3'b010;
    strobe(3'b010);
    step(); step();
    chk("mask010_avail", avail_cnt, a0 + 1);
    rd(1, 0, 0, 0, 3'd5);
    chk("mask_rxn5", rx_dout_A, 16'h0000);
    rd(1, 0, 0, 0, 3'd1);
    chk("mask_ch1", rx_dout_A, 16'hABCD);

    // Reset mid-set
    rx_en = 3'b111;
    strobe(3'b001);
    strobe(3'b001);
    strobe(3'b010);
    chk("pre_rst_ovr", overrun, 3'b001);
    a0 = avail_cnt; w0 = wb_cnt;
    reset_n = 1'b0;
    step(); step();
    chk("midrst_dout", rx_dout_A, 0);
    @(negedge adc_clk);
    reset_n = 1'b1;
    step();
    strobe(3'b100);
    repeat (6) step();
    chk("post_rst_no_avail", avail_cnt, a0);
    chk("post_rst_no_wb", wb_cnt, w0);
    chk("post_rst_avail_lvl", rx_avail_A, 0);
    chk("post_rst_ticks", ticks_A, 0);
    chk("post_rst_ovr", overrun, 0);
    chk("post_rst_dout", rx_dout_A, 0);
    rd(1, 0, 0, 0, 3'd1);
    chk("post_rst_hold", rx_dout_A, 0);
    rd(0, 0, 1, 0, 3'd0);
    chk("post_rst_wb_hold", rx_dout_A, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
